// File: rtl/sdr_data_path_pipe.sv
// sdr_data_path_pipe
//   Parametrised SDRAM data path between the SDRAM control FSM and the DQ/DQM pads.
//   Write side: host beats (WR_VALID/DATAIN/DM) are delayed WR_LAT cycles onto DQOUT/DQ_OE.
//   DQM is delayed WR_LAT-DM_LEAD cycles, so it leads its data beat by DM_LEAD cycles.
//   Read side: a READ command strobe is delayed CAS_LAT cycles. DQIN is then captured for
//   BURST_LEN beats, and a later command truncates the running burst. A driven DQ bus
//   during a capture cycle is flagged as a collision.
//
// Ports
//   CLK        in   1        system clock, rising edge
//   RESET_N    in   1        asynchronous active-low reset
//   WR_VALID   in   1        host write beat valid
//   DATAIN     in   DSIZE    host write data
//   DM         in   DSIZE/8  host byte masks (1 = byte not written)
//   RD_CMD     in   1        READ command issued on the SDRAM bus this cycle
//   DQIN       in   DSIZE    data from the DQ pads
//   DQOUT      out  DSIZE    data to the DQ pads
//   DQ_OE      out  1        DQ pad drive enable
//   DQM        out  DSIZE/8  SDRAM byte masks
//   RD_DATA    out  DSIZE    captured read beat (held while RD_VALID=0)
//   RD_VALID   out  1        RD_DATA holds a new beat
//   RD_BUSY    out  1        read outstanding or burst in progress
//   COLLISION  out  1        DQ was driven during a read capture cycle (one-cycle pulse)
module sdr_data_path_pipe #(
    parameter int unsigned DSIZE     = 32,
    parameter int unsigned WR_LAT    = 2,
    parameter int unsigned DM_LEAD   = 1,
    parameter int unsigned CAS_LAT   = 3,
    parameter int unsigned BURST_LEN = 4
) (
    input  logic               CLK,
    input  logic               RESET_N,
    input  logic               WR_VALID,
    input  logic [DSIZE-1:0]   DATAIN,
    input  logic [DSIZE/8-1:0] DM,
    input  logic               RD_CMD,
    input  logic [DSIZE-1:0]   DQIN,
    output logic [DSIZE-1:0]   DQOUT,
    output logic               DQ_OE,
    output logic [DSIZE/8-1:0] DQM,
    output logic [DSIZE-1:0]   RD_DATA,
    output logic               RD_VALID,
    output logic               RD_BUSY,
    output logic               COLLISION
);

    localparam int unsigned MW    = DSIZE / 8;
    localparam int unsigned M_LAT = (DM_LEAD < WR_LAT) ? (WR_LAT - DM_LEAD) : 1;
    localparam int unsigned CW    = $clog2(BURST_LEN) + 1;
    localparam logic [CW-1:0] BL_CNT = CW'(BURST_LEN);

    // ------------------------------------------------------------------
    // Parameter legality
    // ------------------------------------------------------------------
    if (DSIZE < 8 || (DSIZE % 8) != 0) begin : g_bad_dsize
        $error("sdr_data_path_pipe: DSIZE must be a non-zero multiple of 8");
    end
    if (WR_LAT < 1 || WR_LAT > 4) begin : g_bad_wr_lat
        $error("sdr_data_path_pipe: WR_LAT must be 1..4");
    end
    if (DM_LEAD >= WR_LAT) begin : g_bad_dm_lead
        $error("sdr_data_path_pipe: DM_LEAD must be 0..WR_LAT-1");
    end
    if (CAS_LAT < 2 || CAS_LAT > 3) begin : g_bad_cas_lat
        $error("sdr_data_path_pipe: CAS_LAT must be 2..3");
    end
    if (BURST_LEN != 1 && BURST_LEN != 2 && BURST_LEN != 4 && BURST_LEN != 8) begin : g_bad_burst
        $error("sdr_data_path_pipe: BURST_LEN must be 1, 2, 4 or 8");
    end

    // ------------------------------------------------------------------
    // Write pipe. Data and masks are zeroed on entry when WR_VALID=0, so
    // idle stages present DQOUT=0 / DQM=0 without extra output gating.
    // ------------------------------------------------------------------
    logic [DSIZE-1:0]  wd_pipe [WR_LAT];
    logic [WR_LAT-1:0] wv_pipe;
    logic [MW-1:0]     dm_pipe [M_LAT];

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            for (int unsigned i = 0; i < WR_LAT; i++) begin
                wd_pipe[i] <= '0;
            end
            wv_pipe <= '0;
        end else begin
            wd_pipe[0] <= WR_VALID ? DATAIN : '0;
            wv_pipe[0] <= WR_VALID;
            for (int unsigned i = 1; i < WR_LAT; i++) begin
                wd_pipe[i] <= wd_pipe[i-1];
                wv_pipe[i] <= wv_pipe[i-1];
            end
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            for (int unsigned i = 0; i < M_LAT; i++) begin
                dm_pipe[i] <= '0;
            end
        end else begin
            dm_pipe[0] <= WR_VALID ? DM : '0;
            for (int unsigned i = 1; i < M_LAT; i++) begin
                dm_pipe[i] <= dm_pipe[i-1];
            end
        end
    end

    assign DQOUT = wd_pipe[WR_LAT-1];
    assign DQ_OE = wv_pipe[WR_LAT-1];
    assign DQM   = dm_pipe[M_LAT-1];

    // ------------------------------------------------------------------
    // Read control
    // cmd_sr[k] holds a command issued k+1 cycles ago. Stage CAS_LAT-2 loads
    // the beat counter so it is non-zero exactly during the CAS_LAT..
    // CAS_LAT+BURST_LEN-1 capture cycles. The last stage only extends RD_BUSY
    // over the first capture cycle of a burst.
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_BURST = 2'd2
    } rd_state_t;

    rd_state_t         state, state_next;
    logic [CAS_LAT-1:0] cmd_sr, sr_next;
    logic [CW-1:0]      burst_cnt, cnt_next;
    logic               load;
    logic               pending_next;
    logic               capture;

    always_comb begin
        sr_next      = {cmd_sr[CAS_LAT-2:0], RD_CMD};
        load         = cmd_sr[CAS_LAT-2];
        pending_next = |sr_next[CAS_LAT-2:0];
        cnt_next     = burst_cnt;
        state_next   = state;

        // A strobe reaching the load stage restarts the count even mid-burst.
        if (load) begin
            cnt_next = BL_CNT;
        end else if (burst_cnt != '0) begin
            cnt_next = burst_cnt - 1'b1;
        end

        if (cnt_next != '0) begin
            state_next = S_BURST;
        end else if (pending_next) begin
            state_next = S_WAIT;
        end else begin
            state_next = S_IDLE;
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state     <= S_IDLE;
            cmd_sr    <= '0;
            burst_cnt <= '0;
        end else begin
            state     <= state_next;
            cmd_sr    <= sr_next;
            burst_cnt <= cnt_next;
        end
    end

    assign capture = (state == S_BURST);
    assign RD_BUSY = (|cmd_sr) | (burst_cnt != '0);

    // ------------------------------------------------------------------
    // Read capture and collision flag
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            RD_DATA   <= '0;
            RD_VALID  <= 1'b0;
            COLLISION <= 1'b0;
        end else begin
            if (capture) begin
                RD_DATA <= DQIN;
            end
            RD_VALID  <= capture;
            COLLISION <= capture & DQ_OE;
        end
    end

endmodule

// File: tb/tb_sdr_data_path_pipe.sv
// tb_sdr_data_path_pipe
//   Directed bench for sdr_data_path_pipe. dut_a uses default parameters.
//   dut_b uses WR_LAT=4, DM_LEAD=0 for the long write-latency case.
//   Inputs are driven 1 time unit after a rising edge; "cycle k" is the
//   period after the k-th edge counted from the start of each sequence.
module tb_sdr_data_path_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        wr_valid;
    logic [31:0] datain;
    logic [3:0]  dm;
    logic        rd_cmd;
    logic [31:0] dqin;

    logic [31:0] a_dqout, a_rd_data, b_dqout, b_rd_data;
    logic [3:0]  a_dqm, b_dqm;
    logic        a_dq_oe, a_rd_valid, a_rd_busy, a_collision;
    logic        b_dq_oe, b_rd_valid, b_rd_busy, b_collision;

    int checks = 0;
    int errors = 0;
    int cnt;

    always #5 clk = ~clk;

    sdr_data_path_pipe dut_a (
        .CLK(clk), .RESET_N(rst_n), .WR_VALID(wr_valid), .DATAIN(datain), .DM(dm),
        .RD_CMD(rd_cmd), .DQIN(dqin), .DQOUT(a_dqout), .DQ_OE(a_dq_oe), .DQM(a_dqm),
        .RD_DATA(a_rd_data), .RD_VALID(a_rd_valid), .RD_BUSY(a_rd_busy), .COLLISION(a_collision)
    );

    sdr_data_path_pipe #(.WR_LAT(4), .DM_LEAD(0)) dut_b (
        .CLK(clk), .RESET_N(rst_n), .WR_VALID(wr_valid), .DATAIN(datain), .DM(dm),
        .RD_CMD(rd_cmd), .DQIN(dqin), .DQOUT(b_dqout), .DQ_OE(b_dq_oe), .DQM(b_dqm),
        .RD_DATA(b_rd_data), .RD_VALID(b_rd_valid), .RD_BUSY(b_rd_busy), .COLLISION(b_collision)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_a_dq"},  64'(a_dqout), 64'(0));
        check({tag, "_a_rd"},  64'(a_rd_data), 64'(0));
        check({tag, "_a_ctl"}, 64'({a_dq_oe, a_dqm, a_rd_valid, a_rd_busy, a_collision}), 64'(0));
        check({tag, "_b_dq"},  64'(b_dqout), 64'(0));
        check({tag, "_b_rd"},  64'(b_rd_data), 64'(0));
        check({tag, "_b_ctl"}, 64'({b_dq_oe, b_dqm, b_rd_valid, b_rd_busy, b_collision}), 64'(0));
    endtask

    task automatic idle_inputs();
        wr_valid = 1'b0;
        rd_cmd   = 1'b0;
        datain   = '0;
        dm       = '0;
        dqin     = '0;
    endtask

    initial begin
        // 1: reset held with live stimulus -> everything stays 0
        rst_n    = 1'b0;
        wr_valid = 1'b1;
        datain   = 32'hFFFF_0000;
        dm       = 4'hF;
        dqin     = 32'h5555_AAAA;
        rd_cmd   = 1'b0;
        for (int k = 0; k < 6; k++) begin
            rd_cmd = k[0];
            datain = datain + 32'd1;
            tick();
            check_all_zero("rst");
        end
        idle_inputs();
        rst_n = 1'b1;
        repeat (3) tick();

        // 2: single write beat, defaults (WR_LAT=2, DM_LEAD=1)
        wr_valid = 1'b1;
        datain   = 32'hA5A5_0001;
        dm       = 4'b0010;
        tick();
        wr_valid = 1'b0;
        datain   = 32'hFFFF_FFFF;
        dm       = 4'b1111;
        check("wr1_t1_dqm", 64'(a_dqm), 64'(4'b0010));
        check("wr1_t1_oe",  64'(a_dq_oe), 64'(0));
        check("wr1_t1_dq",  64'(a_dqout), 64'(0));
        tick();
        check("wr1_t2_dq",  64'(a_dqout), 64'(32'hA5A5_0001));
        check("wr1_t2_oe",  64'(a_dq_oe), 64'(1));
        check("wr1_t2_dqm", 64'(a_dqm), 64'(0));
        tick();
        check("wr1_t3_dq",  64'(a_dqout), 64'(0));
        check("wr1_t3_oe",  64'(a_dq_oe), 64'(0));
        check("wr1_t3_dqm", 64'(a_dqm), 64'(0));
        idle_inputs();
        repeat (3) tick();

        // 3: 8 back-to-back beats on dut_b (WR_LAT=4, DM_LEAD=0)
        cnt = 0;
        for (int k = 0; k < 13; k++) begin
            if (k < 8) begin
                wr_valid = 1'b1;
                datain   = k + 1;
                dm       = 4'(k + 1);
            end else begin
                idle_inputs();
            end
            tick();
            begin
                int k1;
                logic on;
                k1 = k + 1;
                on = (k1 >= 4 && k1 <= 11);
                check("burstwr_dq",  64'(b_dqout), on ? 64'(k1 - 3) : 64'(0));
                check("burstwr_dqm", 64'(b_dqm),   on ? 64'((k1 - 3) & 15) : 64'(0));
                check("burstwr_oe",  64'(b_dq_oe), 64'(on));
                if (b_dq_oe) cnt++;
            end
        end
        check("burstwr_oe_cycles", 64'(cnt), 64'(8));
        idle_inputs();
        repeat (4) tick();

        // 4: single read, CAS_LAT=3, BURST_LEN=4, DQIN = beat index
        for (int k = 0; k < 11; k++) begin
            rd_cmd = (k == 0);
            dqin   = (k >= 3 && k <= 6) ? 32'(k - 3) : 32'hBAD0_0000 + 32'(k);
            tick();
            begin
                int k1;
                logic v;
                k1 = k + 1;
                v  = (k1 >= 4 && k1 <= 7);
                check("rd_valid", 64'(a_rd_valid), 64'(v));
                check("rd_busy",  64'(a_rd_busy),  64'(k1 >= 1 && k1 <= 6));
                if (v) check("rd_data", 64'(a_rd_data), 64'(k1 - 4));
                if (k1 >= 8) check("rd_hold", 64'(a_rd_data), 64'(3));
            end
        end
        idle_inputs();
        repeat (3) tick();

        // 5: second command two cycles later truncates the first burst
        cnt = 0;
        for (int k = 0; k < 12; k++) begin
            rd_cmd = (k == 0 || k == 2);
            dqin   = 32'h100 + 32'(k);
            tick();
            begin
                int k1;
                logic v;
                k1 = k + 1;
                v  = (k1 >= 4 && k1 <= 9);
                check("intr_valid", 64'(a_rd_valid), 64'(v));
                check("intr_busy",  64'(a_rd_busy),  64'(k1 >= 1 && k1 <= 8));
                if (v) check("intr_data", 64'(a_rd_data), 64'(32'h100 + 32'(k1 - 1)));
                if (a_rd_valid) cnt++;
            end
        end
        check("intr_valid_cycles", 64'(cnt), 64'(6));
        idle_inputs();
        repeat (3) tick();

        // 6: write beat lands on capture cycle 4 -> COLLISION in cycle 5,
        //    then reset mid-burst
        for (int k = 0; k < 5; k++) begin
            rd_cmd   = (k == 0);
            wr_valid = (k == 2);
            datain   = (k == 2) ? 32'h1234_5678 : 32'h0;
            dm       = '0;
            dqin     = 32'hC000_0000 + 32'(k);
            tick();
            begin
                int k1;
                k1 = k + 1;
                check("col_pulse", 64'(a_collision), 64'(k1 == 5));
                check("col_oe",    64'(a_dq_oe),     64'(k1 == 4));
                if (k1 == 4) check("col_dq", 64'(a_dqout), 64'(32'h1234_5678));
                if (k1 >= 4) check("col_rd_valid", 64'(a_rd_valid), 64'(1));
            end
        end
        idle_inputs();
        rst_n = 1'b0;
        #1;
        check_all_zero("midrst");
        tick();
        rst_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            tick();
            check("postrst_a", 64'({a_rd_valid, a_rd_busy, a_collision, a_dq_oe}), 64'(0));
            check("postrst_b", 64'({b_rd_valid, b_rd_busy, b_collision, b_dq_oe}), 64'(0));
        end
        // recovery: a fresh command works normally
        for (int k = 0; k < 4; k++) begin
            rd_cmd = (k == 0);
            dqin   = 32'h77;
            tick();
            check("recover_valid", 64'(a_rd_valid), 64'(k == 3));
            if (k == 3) check("recover_data", 64'(a_rd_data), 64'(32'h77));
        end
        idle_inputs();
        repeat (2) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
